// File: rtl/gpu_sched_pkg.sv
// Shared types for the GPU block scheduler: top-level and per-core state
// encodings plus the width of the per-core thread count.
package gpu_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE,
        ST_ABORT
    } top_state_t;

    typedef enum logic [1:0] {
        CORE_FREE,
        CORE_ARMED,
        CORE_RUNNING
    } core_state_t;

    // Wide enough to hold a full block count (TPB itself, not TPB-1).
    function automatic int unsigned core_tc_bits(input int unsigned tpb);
        return $clog2(tpb) + 1;
    endfunction

endpackage

// File: rtl/rr_free_picker.sv
// Combinational round-robin search: grants the first free core at or after
// the pointer, wrapping around the core index space.
module rr_free_picker #(
    parameter int unsigned NUM_CORES = 2,
    parameter int unsigned PTR_BITS  = 1
) (
    input  logic [NUM_CORES-1:0] free,
    input  logic [PTR_BITS-1:0]  ptr,
    output logic [NUM_CORES-1:0] grant,
    output logic                 valid
);

    logic [PTR_BITS-1:0] idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            idx = PTR_BITS'((32'(ptr) + i) % NUM_CORES);
            if (!valid && free[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpu_block_scheduler.sv
// Kernel dispatcher: splits a kernel into thread blocks and issues each block
// to the next free core in round-robin order, with abort and retirement count.
module gpu_block_scheduler
    import gpu_sched_pkg::*;
#(
    parameter int unsigned NUM_CORES         = 2,
    parameter int unsigned THREADS_PER_BLOCK = 4,
    parameter int unsigned THREAD_COUNT_BITS = 8,
    parameter int unsigned BLOCK_ID_BITS     = 8
) (
    input  logic                                                         clk,
    input  logic                                                         reset,
    input  logic                                                         start,
    input  logic                                                         abort,
    input  logic [THREAD_COUNT_BITS-1:0]                                 thread_count,
    input  logic [NUM_CORES-1:0]                                         core_done,
    output logic [NUM_CORES-1:0]                                         core_start,
    output logic [NUM_CORES-1:0]                                         core_reset,
    output logic [NUM_CORES-1:0][BLOCK_ID_BITS-1:0]                      core_block_id,
    output logic [NUM_CORES-1:0][core_tc_bits(THREADS_PER_BLOCK)-1:0]    core_thread_count,
    output logic                                                         busy,
    output logic                                                         done,
    output logic [THREAD_COUNT_BITS-1:0]                                 blocks_done
);

    localparam int unsigned CORE_TC_BITS = core_tc_bits(THREADS_PER_BLOCK);
    localparam int unsigned TPB_LOG2     = $clog2(THREADS_PER_BLOCK);
    localparam int unsigned PTR_BITS     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [THREAD_COUNT_BITS-1:0] TPB_W = THREAD_COUNT_BITS'(THREADS_PER_BLOCK);

    top_state_t                   state_q, state_d;
    core_state_t                  core_state_q [NUM_CORES];
    logic [THREAD_COUNT_BITS-1:0] tc_q;
    logic [THREAD_COUNT_BITS-1:0] total_q;
    logic [THREAD_COUNT_BITS-1:0] next_q;
    logic [PTR_BITS-1:0]          ptr_q;

    logic [NUM_CORES-1:0]         free_mask;
    logic [NUM_CORES-1:0]         grant;
    logic                         grant_valid;
    logic [PTR_BITS-1:0]          grant_idx;
    logic [PTR_BITS-1:0]          ptr_next;
    logic [NUM_CORES-1:0]         retire;
    logic [THREAD_COUNT_BITS-1:0] retire_cnt;
    logic [THREAD_COUNT_BITS-1:0] remain;
    logic [CORE_TC_BITS-1:0]      issue_count;
    logic [THREAD_COUNT_BITS-1:0] launch_total;
    logic                         launch;
    logic                         abort_hit;
    logic                         issue;

    rr_free_picker #(
        .NUM_CORES (NUM_CORES),
        .PTR_BITS  (PTR_BITS)
    ) u_picker (
        .free  (free_mask),
        .ptr   (ptr_q),
        .grant (grant),
        .valid (grant_valid)
    );

    assign launch    = (state_q == ST_IDLE) && start && !abort;
    assign abort_hit = abort && ((state_q == ST_RUN) || (state_q == ST_DONE));
    assign issue     = (state_q == ST_RUN) && !abort && (next_q < total_q) && grant_valid;
    assign busy      = (state_q == ST_RUN) || (state_q == ST_ABORT);
    assign done      = (state_q == ST_DONE);

    // Ceiling division written as quotient + remainder-nonzero so it cannot
    // overflow for thread counts near the top of the range.
    assign launch_total = (thread_count >> TPB_LOG2)
                        + THREAD_COUNT_BITS'((thread_count & (TPB_W - 1'b1)) != '0);

    assign remain      = tc_q - (next_q << TPB_LOG2);
    assign issue_count = (remain >= TPB_W) ? CORE_TC_BITS'(THREADS_PER_BLOCK)
                                           : remain[CORE_TC_BITS-1:0];

    always_comb begin
        free_mask  = '0;
        retire     = '0;
        retire_cnt = '0;
        grant_idx  = '0;
        for (int unsigned c = 0; c < NUM_CORES; c++) begin
            free_mask[c] = (core_state_q[c] == CORE_FREE);
            retire[c]    = (state_q == ST_RUN) && (core_state_q[c] == CORE_RUNNING) && core_done[c];
            retire_cnt   = retire_cnt + THREAD_COUNT_BITS'(retire[c]);
            if (grant[c]) begin
                grant_idx = PTR_BITS'(c);
            end
        end
        ptr_next = (grant_idx == PTR_BITS'(NUM_CORES - 1)) ? '0 : grant_idx + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start && !abort) state_d = ST_RUN;
            ST_RUN: begin
                if (abort)                        state_d = ST_ABORT;
                else if (blocks_done == total_q)  state_d = ST_DONE;
            end
            ST_DONE: begin
                if (abort)       state_d = ST_ABORT;
                else if (!start) state_d = ST_IDLE;
            end
            ST_ABORT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tc_q        <= '0;
            total_q     <= '0;
            next_q      <= '0;
            ptr_q       <= '0;
            blocks_done <= '0;
        end else if (launch) begin
            tc_q        <= thread_count;
            total_q     <= launch_total;
            next_q      <= '0;
            ptr_q       <= '0;
            blocks_done <= '0;
        end else if (!abort_hit) begin
            blocks_done <= blocks_done + retire_cnt;
            if (issue) begin
                next_q <= next_q + 1'b1;
                ptr_q  <= ptr_next;
            end
        end
    end

    // A FREE core drops core_reset every cycle unless it is re-issued, which
    // makes both the retire and issue resets single-cycle pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            core_start        <= '0;
            core_reset        <= '0;
            core_block_id     <= '0;
            core_thread_count <= '0;
            for (int unsigned c = 0; c < NUM_CORES; c++) begin
                core_state_q[c] <= CORE_FREE;
            end
        end else begin
            for (int unsigned c = 0; c < NUM_CORES; c++) begin
                if (abort_hit) begin
                    core_state_q[c] <= CORE_FREE;
                    core_start[c]   <= 1'b0;
                    core_reset[c]   <= 1'b1;
                end else begin
                    unique case (core_state_q[c])
                        CORE_FREE: begin
                            if (issue && grant[c]) begin
                                core_state_q[c]      <= CORE_ARMED;
                                core_reset[c]        <= 1'b1;
                                core_block_id[c]     <= BLOCK_ID_BITS'(next_q);
                                core_thread_count[c] <= issue_count;
                            end else begin
                                core_reset[c] <= 1'b0;
                            end
                        end
                        CORE_ARMED: begin
                            core_state_q[c] <= CORE_RUNNING;
                            core_reset[c]   <= 1'b0;
                            core_start[c]   <= 1'b1;
                        end
                        CORE_RUNNING: begin
                            if (retire[c]) begin
                                core_state_q[c] <= CORE_FREE;
                                core_start[c]   <= 1'b0;
                                core_reset[c]   <= 1'b1;
                            end
                        end
                        default: core_state_q[c] <= CORE_FREE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_gpu_block_scheduler.sv
// Directed bench for gpu_block_scheduler with NUM_CORES=2, TPB=4.
module tb_gpu_block_scheduler;

    logic             clk;
    logic             reset;
    logic             start;
    logic             abort;
    logic [7:0]       thread_count;
    logic [1:0]       core_done;
    logic [1:0]       core_start;
    logic [1:0]       core_reset;
    logic [1:0][7:0]  core_block_id;
    logic [1:0][2:0]  core_thread_count;
    logic             busy;
    logic             done;
    logic [7:0]       blocks_done;

    int total;
    int bad;

    gpu_block_scheduler #(
        .NUM_CORES         (2),
        .THREADS_PER_BLOCK (4),
        .THREAD_COUNT_BITS (8),
        .BLOCK_ID_BITS     (8)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .abort             (abort),
        .thread_count      (thread_count),
        .core_done         (core_done),
        .core_start        (core_start),
        .core_reset        (core_reset),
        .core_block_id     (core_block_id),
        .core_thread_count (core_thread_count),
        .busy              (busy),
        .done              (done),
        .blocks_done       (blocks_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; abort = 1'b0; thread_count = '0; core_done = '0;
        tick(); tick();
        total++;
        if ({core_start, core_reset, busy, done} !== 6'b0 || blocks_done !== 8'd0) begin
            bad++;
            $display("FAIL reset_outputs got start/reset/busy/done=%b blocks=%0d want 000000 0",
                     {core_start, core_reset, busy, done}, blocks_done);
        end
        total++;
        if (core_block_id !== 16'd0 || core_thread_count !== 6'd0) begin
            bad++;
            $display("FAIL reset_ids got id=%h cnt=%h want 0 0", core_block_id, core_thread_count);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_tc8();
        start = 1'b1; thread_count = 8'd8;
        tick();
        total++;
        if ({busy, done, core_start, core_reset} !== 6'b100000) begin
            bad++;
            $display("FAIL tc8_launch got %b want 100000", {busy, done, core_start, core_reset});
        end
        tick();
        total++;
        if ({core_start, core_reset} !== 4'b0001 || core_block_id[0] !== 8'd0 || core_thread_count[0] !== 3'd4) begin
            bad++;
            $display("FAIL tc8_issue0 got sr=%b id=%0d cnt=%0d want 0001 0 4",
                     {core_start, core_reset}, core_block_id[0], core_thread_count[0]);
        end
        tick();
        total++;
        if ({core_start, core_reset} !== 4'b0110 || core_block_id[1] !== 8'd1 || core_thread_count[1] !== 3'd4) begin
            bad++;
            $display("FAIL tc8_issue1 got sr=%b id=%0d cnt=%0d want 0110 1 4",
                     {core_start, core_reset}, core_block_id[1], core_thread_count[1]);
        end
        tick();
        total++;
        if ({core_start, core_reset} !== 4'b1100) begin
            bad++;
            $display("FAIL tc8_running got %b want 1100", {core_start, core_reset});
        end
        core_done = 2'b11;
        tick();
        core_done = 2'b00;
        total++;
        if (blocks_done !== 8'd2 || {core_start, core_reset} !== 4'b0011 || done !== 1'b0) begin
            bad++;
            $display("FAIL tc8_retire got blocks=%0d sr=%b done=%b want 2 0011 0",
                     blocks_done, {core_start, core_reset}, done);
        end
        tick();
        total++;
        if ({done, busy, core_reset} !== 4'b1000 || blocks_done !== 8'd2) begin
            bad++;
            $display("FAIL tc8_done got done/busy/reset=%b blocks=%0d want 1000 2",
                     {done, busy, core_reset}, blocks_done);
        end
        tick();
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL tc8_done_hold got %b want 1", done);
        end
        start = 1'b0;
        tick();
        total++;
        if ({done, busy} !== 2'b00) begin
            bad++;
            $display("FAIL tc8_idle got %b want 00", {done, busy});
        end
    endtask

    task automatic test_tc10();
        start = 1'b1; thread_count = 8'd10;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        core_done = 2'b10;
        tick();
        core_done = 2'b00;
        total++;
        if ({core_start, core_reset} !== 4'b0110 || blocks_done !== 8'd1) begin
            bad++;
            $display("FAIL tc10_core1_retire got sr=%b blocks=%0d want 0110 1",
                     {core_start, core_reset}, blocks_done);
        end
        tick();
        total++;
        if ({core_start, core_reset} !== 4'b0110 || core_block_id[1] !== 8'd2 || core_thread_count[1] !== 3'd2) begin
            bad++;
            $display("FAIL tc10_partial_issue got sr=%b id=%0d cnt=%0d want 0110 2 2",
                     {core_start, core_reset}, core_block_id[1], core_thread_count[1]);
        end
        tick();
        total++;
        if ({core_start, core_reset} !== 4'b1100) begin
            bad++;
            $display("FAIL tc10_running got %b want 1100", {core_start, core_reset});
        end
        core_done = 2'b01;
        tick();
        core_done = 2'b10;
        total++;
        if ({core_start, core_reset} !== 4'b1001 || blocks_done !== 8'd2 || done !== 1'b0) begin
            bad++;
            $display("FAIL tc10_retire2 got sr=%b blocks=%0d done=%b want 1001 2 0",
                     {core_start, core_reset}, blocks_done, done);
        end
        tick();
        core_done = 2'b00;
        total++;
        if ({core_start, core_reset} !== 4'b0010 || blocks_done !== 8'd3 || done !== 1'b0) begin
            bad++;
            $display("FAIL tc10_retire3 got sr=%b blocks=%0d done=%b want 0010 3 0",
                     {core_start, core_reset}, blocks_done, done);
        end
        tick();
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL tc10_done got %b want 1", done);
        end
        tick();
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL tc10_idle got %b want 0", done);
        end
    endtask

    task automatic test_tc0();
        start = 1'b1; thread_count = 8'd0;
        tick();
        total++;
        if ({busy, done, core_start, core_reset} !== 6'b100000) begin
            bad++;
            $display("FAIL tc0_run got %b want 100000", {busy, done, core_start, core_reset});
        end
        tick();
        total++;
        if ({busy, done, core_start, core_reset} !== 6'b010000 || blocks_done !== 8'd0) begin
            bad++;
            $display("FAIL tc0_done got %b blocks=%0d want 010000 0",
                     {busy, done, core_start, core_reset}, blocks_done);
        end
        start = 1'b0;
        tick();
        total++;
        if ({busy, done, core_start, core_reset} !== 6'b000000) begin
            bad++;
            $display("FAIL tc0_idle got %b want 000000", {busy, done, core_start, core_reset});
        end
    endtask

    task automatic test_back_to_back();
        start = 1'b1; thread_count = 8'd16;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        core_done = 2'b11;
        tick();
        core_done = 2'b00;
        total++;
        if (blocks_done !== 8'd2 || {core_start, core_reset} !== 4'b0011) begin
            bad++;
            $display("FAIL b2b_retire got blocks=%0d sr=%b want 2 0011", blocks_done, {core_start, core_reset});
        end
        tick();
        total++;
        if ({core_start, core_reset} !== 4'b0001 || core_block_id[0] !== 8'd2 || core_thread_count[0] !== 3'd4) begin
            bad++;
            $display("FAIL b2b_issue2 got sr=%b id=%0d cnt=%0d want 0001 2 4",
                     {core_start, core_reset}, core_block_id[0], core_thread_count[0]);
        end
        tick();
        total++;
        if ({core_start, core_reset} !== 4'b0110 || core_block_id[1] !== 8'd3 || core_thread_count[1] !== 3'd4) begin
            bad++;
            $display("FAIL b2b_issue3 got sr=%b id=%0d cnt=%0d want 0110 3 4",
                     {core_start, core_reset}, core_block_id[1], core_thread_count[1]);
        end
        tick();
        core_done = 2'b11;
        tick();
        core_done = 2'b00;
        total++;
        if (blocks_done !== 8'd4 || done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_retire4 got blocks=%0d done=%b want 4 0", blocks_done, done);
        end
        tick();
        total++;
        if ({done, busy} !== 2'b10) begin
            bad++;
            $display("FAIL b2b_done got %b want 10", {done, busy});
        end
        tick();
    endtask

    task automatic test_abort();
        start = 1'b1; thread_count = 8'd16;
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        total++;
        if ({core_start, core_reset} !== 4'b1100) begin
            bad++;
            $display("FAIL abort_pre got %b want 1100", {core_start, core_reset});
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++;
        if ({core_start, core_reset, busy, done} !== 6'b001110) begin
            bad++;
            $display("FAIL abort_edge got %b want 001110", {core_start, core_reset, busy, done});
        end
        tick();
        total++;
        if ({core_start, core_reset, busy, done} !== 6'b000000) begin
            bad++;
            $display("FAIL abort_idle got %b want 000000", {core_start, core_reset, busy, done});
        end
    endtask

    task automatic test_async_reset();
        start = 1'b1; thread_count = 8'd8;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        #2 reset = 1'b0;
        #1;
        total++;
        if ({core_start, core_reset, busy, done} !== 6'b0 || core_block_id !== 16'd0 || core_thread_count !== 6'd0) begin
            bad++;
            $display("FAIL async_reset got sr/bd=%b id=%h cnt=%h want 0 0 0",
                     {core_start, core_reset, busy, done}, core_block_id, core_thread_count);
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
        start = 1'b1; thread_count = 8'd4;
        tick();
        start = 1'b0;
        tick();
        total++;
        if ({core_start, core_reset} !== 4'b0001 || core_thread_count[0] !== 3'd4 || core_block_id[0] !== 8'd0) begin
            bad++;
            $display("FAIL rerun_issue got sr=%b id=%0d cnt=%0d want 0001 0 4",
                     {core_start, core_reset}, core_block_id[0], core_thread_count[0]);
        end
        tick();
        core_done = 2'b01;
        tick();
        core_done = 2'b00;
        total++;
        if (blocks_done !== 8'd1 || {core_start, core_reset} !== 4'b0001) begin
            bad++;
            $display("FAIL rerun_retire got blocks=%0d sr=%b want 1 0001", blocks_done, {core_start, core_reset});
        end
        tick();
        total++;
        if ({done, busy} !== 2'b10) begin
            bad++;
            $display("FAIL rerun_done got %b want 10", {done, busy});
        end
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_tc8();
        test_tc10();
        test_tc0();
        test_back_to_back();
        test_abort();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
